// File: rtl/config_sched_pkg.sv
// Shared types, defaults and register-bank helpers for the frame-synchronous
// configuration scheduler.
package config_sched_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned COLOR_W  = 6;
  localparam int unsigned POS_W    = 8;
  localparam int unsigned MISC_W   = 5;
  localparam int unsigned NUM_REGS = 7;

  localparam logic [COLOR_W-1:0] COLOR1_DEFAULT   = 6'b110001;
  localparam logic [COLOR_W-1:0] COLOR2_DEFAULT   = 6'b010101;
  localparam logic [COLOR_W-1:0] COLOR3_DEFAULT   = 6'b001100;
  localparam logic [COLOR_W-1:0] COLOR4_DEFAULT   = 6'b101100;
  localparam logic [POS_W-1:0]   SPRITE_X_DEFAULT = 8'd0;
  localparam logic [POS_W-1:0]   SPRITE_Y_DEFAULT = 8'd0;
  localparam logic [MISC_W-1:0]  MISC_DEFAULT     = 5'b00110;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_COLOR1   = 3'd0,
    ADDR_COLOR2   = 3'd1,
    ADDR_COLOR3   = 3'd2,
    ADDR_COLOR4   = 3'd3,
    ADDR_SPRITE_X = 3'd4,
    ADDR_SPRITE_Y = 3'd5,
    ADDR_MISC     = 3'd6,
    ADDR_CTRL     = 3'd7
  } cfg_addr_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } sched_state_e;

  // One full configuration bank; used for both shadow and active copies.
  typedef struct packed {
    logic [COLOR_W-1:0] color1;
    logic [COLOR_W-1:0] color2;
    logic [COLOR_W-1:0] color3;
    logic [COLOR_W-1:0] color4;
    logic [POS_W-1:0]   sprite_x;
    logic [POS_W-1:0]   sprite_y;
    logic [MISC_W-1:0]  misc;
  } cfg_regs_t;

  localparam cfg_regs_t CFG_DEFAULT = '{
    color1:   COLOR1_DEFAULT,
    color2:   COLOR2_DEFAULT,
    color3:   COLOR3_DEFAULT,
    color4:   COLOR4_DEFAULT,
    sprite_x: SPRITE_X_DEFAULT,
    sprite_y: SPRITE_Y_DEFAULT,
    misc:     MISC_DEFAULT
  };

  // Apply one register write to a bank; unused data bits are dropped.
  function automatic cfg_regs_t cfg_write(input cfg_regs_t regs,
                                          input cfg_addr_e addr,
                                          input logic [DATA_W-1:0] data);
    cfg_regs_t res;
    res = regs;
    case (addr)
      ADDR_COLOR1:   res.color1   = data[COLOR_W-1:0];
      ADDR_COLOR2:   res.color2   = data[COLOR_W-1:0];
      ADDR_COLOR3:   res.color3   = data[COLOR_W-1:0];
      ADDR_COLOR4:   res.color4   = data[COLOR_W-1:0];
      ADDR_SPRITE_X: res.sprite_x = data[POS_W-1:0];
      ADDR_SPRITE_Y: res.sprite_y = data[POS_W-1:0];
      ADDR_MISC:     res.misc     = data[MISC_W-1:0];
      default:       res          = regs;
    endcase
    return res;
  endfunction

  // Copy only the dirty fields of the shadow bank over the active bank.
  function automatic cfg_regs_t cfg_merge(input cfg_regs_t active,
                                          input cfg_regs_t shadow,
                                          input logic [NUM_REGS-1:0] dirty);
    cfg_regs_t res;
    res = active;
    if (dirty[ADDR_COLOR1])   res.color1   = shadow.color1;
    if (dirty[ADDR_COLOR2])   res.color2   = shadow.color2;
    if (dirty[ADDR_COLOR3])   res.color3   = shadow.color3;
    if (dirty[ADDR_COLOR4])   res.color4   = shadow.color4;
    if (dirty[ADDR_SPRITE_X]) res.sprite_x = shadow.sprite_x;
    if (dirty[ADDR_SPRITE_Y]) res.sprite_y = shadow.sprite_y;
    if (dirty[ADDR_MISC])     res.misc     = shadow.misc;
    return res;
  endfunction

  // Dirty-mask bit for a data register; the control address has none.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input cfg_addr_e addr);
    logic [NUM_REGS-1:0] res;
    res = '0;
    if (addr != ADDR_CTRL) res = NUM_REGS'(1) << addr;
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; a 1-bit pointer records who lost the
// last contested cycle so that requester wins the next contest.
module rr_arbiter2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_c,
  output logic gnt_b_c
);

  logic prio_b_q;
  logic contest_c;

  always_comb begin
    contest_c = en_i && req_a_i && req_b_i;
    gnt_a_c   = en_i && req_a_i && (!req_b_i || !prio_b_q);
    gnt_b_c   = en_i && req_b_i && (!req_a_i ||  prio_b_q);
  end

  // Only contested cycles move the pointer; the winner loses priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_b_q <= 1'b0;
    end else if (contest_c) begin
      prio_b_q <= gnt_a_c;
    end
  end

endmodule

// File: rtl/config_scheduler.sv
// Frame-synchronous configuration controller: arbitrates writes from two
// requesters into a shadow bank and commits dirty fields at frame boundaries.
module config_scheduler
  import config_sched_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                next_frame,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W-1:0]   a_data_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_data_i,
  output logic [COLOR_W-1:0]  color1_o,
  output logic [COLOR_W-1:0]  color2_o,
  output logic [COLOR_W-1:0]  color3_o,
  output logic [COLOR_W-1:0]  color4_o,
  output logic [POS_W-1:0]    sprite_x_o,
  output logic [POS_W-1:0]    sprite_y_o,
  output logic [MISC_W-1:0]   misc_o,
  output logic                pending_o,
  output logic                frozen_o,
  output logic                commit_o
);

  sched_state_e        state_q, state_d;
  cfg_regs_t           shadow_q, active_q;
  logic [NUM_REGS-1:0] dirty_q;
  logic                freeze_q;
  logic                commit_q;
  logic                pending_q;

  logic                arb_en_c;
  logic                gnt_a_c, gnt_b_c;
  logic                wr_en_c;
  cfg_addr_e           wr_addr_c;
  logic [DATA_W-1:0]   wr_data_c;
  logic                reg_wr_c;
  logic                ctrl_wr_c;

  // No write may land during the commit cycle or while reset is asserted.
  assign arb_en_c = rst_ni && (state_q != COMMIT);

  rr_arbiter2 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (arb_en_c),
    .req_a_i (a_valid_i),
    .req_b_i (b_valid_i),
    .gnt_a_c (gnt_a_c),
    .gnt_b_c (gnt_b_c)
  );

  assign a_ready_o = gnt_a_c;
  assign b_ready_o = gnt_b_c;

  // Select the accepted write and classify it.
  always_comb begin
    wr_en_c   = gnt_a_c || gnt_b_c;
    wr_addr_c = cfg_addr_e'(gnt_b_c ? b_addr_i : a_addr_i);
    wr_data_c = gnt_b_c ? b_data_i : a_data_i;
    reg_wr_c  = wr_en_c && (wr_addr_c != ADDR_CTRL);
    ctrl_wr_c = wr_en_c && (wr_addr_c == ADDR_CTRL);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; freeze holds ARMED across frame pulses.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (reg_wr_c) state_d = ARMED;
      ARMED:   if (next_frame && !freeze_q) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow/active banks, dirty mask, freeze and status flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q  <= CFG_DEFAULT;
      active_q  <= CFG_DEFAULT;
      dirty_q   <= '0;
      freeze_q  <= 1'b0;
      commit_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      commit_q  <= (state_q == COMMIT);
      pending_q <= (state_d != IDLE);
      if (state_q == COMMIT) begin
        active_q <= cfg_merge(active_q, shadow_q, dirty_q);
        dirty_q  <= '0;
      end else if (reg_wr_c) begin
        shadow_q <= cfg_write(shadow_q, wr_addr_c, wr_data_c);
        dirty_q  <= dirty_q | addr_onehot(wr_addr_c);
      end
      if (ctrl_wr_c) begin
        freeze_q <= wr_data_c[0];
      end
    end
  end

  assign color1_o   = active_q.color1;
  assign color2_o   = active_q.color2;
  assign color3_o   = active_q.color3;
  assign color4_o   = active_q.color4;
  assign sprite_x_o = active_q.sprite_x;
  assign sprite_y_o = active_q.sprite_y;
  assign misc_o     = active_q.misc;
  assign pending_o  = pending_q;
  assign frozen_o   = freeze_q;
  assign commit_o   = commit_q;

endmodule

// File: tb/tb_config_scheduler.sv
// Self-checking bench for config_scheduler: directed scenarios plus random
// traffic, all compared against a frame-level reference model.
module tb_config_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       next_frame;
  logic       a_valid_i, b_valid_i;
  logic       a_ready_o, b_ready_o;
  logic [2:0] a_addr_i, b_addr_i;
  logic [7:0] a_data_i, b_data_i;
  logic [5:0] color1_o, color2_o, color3_o, color4_o;
  logic [7:0] sprite_x_o, sprite_y_o;
  logic [4:0] misc_o;
  logic       pending_o, frozen_o, commit_o;

  config_scheduler dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .next_frame (next_frame),
    .a_valid_i  (a_valid_i),
    .a_ready_o  (a_ready_o),
    .a_addr_i   (a_addr_i),
    .a_data_i   (a_data_i),
    .b_valid_i  (b_valid_i),
    .b_ready_o  (b_ready_o),
    .b_addr_i   (b_addr_i),
    .b_data_i   (b_data_i),
    .color1_o   (color1_o),
    .color2_o   (color2_o),
    .color3_o   (color3_o),
    .color4_o   (color4_o),
    .sprite_x_o (sprite_x_o),
    .sprite_y_o (sprite_y_o),
    .misc_o     (misc_o),
    .pending_o  (pending_o),
    .frozen_o   (frozen_o),
    .commit_o   (commit_o)
  );

  always #5 clk_i = ~clk_i;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: register values as plain integers, commit copies the
  // whole shadow image (untouched fields already equal the active ones).
  int DEF [7] = '{'h31, 'h15, 'h0C, 'h2C, 0, 0, 'h06};
  int m_shadow [7];
  int m_active [7];
  bit m_pending, m_commit_cycle, m_frozen, m_commit_exp;
  bit m_last_contest_b;
  bit m_gnt_a, m_gnt_b;
  logic obs_a_rdy, obs_b_rdy;

  function automatic int reg_mask(input int a);
    if (a < 4)  return 'h3F;
    if (a == 6) return 'h1F;
    return 'hFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin
      m_shadow[i] = DEF[i];
      m_active[i] = DEF[i];
    end
    m_pending = 0; m_commit_cycle = 0; m_frozen = 0; m_commit_exp = 0;
    m_last_contest_b = 1;  // so A wins the first contest
  endtask

  task automatic set_idle();
    next_frame = 0;
    a_valid_i = 0; a_addr_i = '0; a_data_i = '0;
    b_valid_i = 0; b_addr_i = '0; b_data_i = '0;
  endtask

  // One clock cycle: check ready before the edge, advance model, check outputs.
  task automatic cycle();
    bit en, arm;
    int addr, data;
    #2;
    en      = rst_ni && !m_commit_cycle;
    m_gnt_a = en && a_valid_i && (!b_valid_i || m_last_contest_b);
    m_gnt_b = en && b_valid_i && (!a_valid_i || !m_last_contest_b);
    obs_a_rdy = a_ready_o;
    obs_b_rdy = b_ready_o;
    check("a_ready", a_ready_o, m_gnt_a);
    check("b_ready", b_ready_o, m_gnt_b);
    @(posedge clk_i);
    if (!rst_ni) begin
      model_reset();
    end else if (m_commit_cycle) begin
      for (int i = 0; i < 7; i++) m_active[i] = m_shadow[i];
      m_commit_exp = 1; m_commit_cycle = 0; m_pending = 0;
    end else begin
      m_commit_exp = 0;
      arm = m_pending && next_frame && !m_frozen;
      if (m_gnt_a || m_gnt_b) begin
        addr = m_gnt_b ? int'(b_addr_i) : int'(a_addr_i);
        data = m_gnt_b ? int'(b_data_i) : int'(a_data_i);
        if (a_valid_i && b_valid_i) m_last_contest_b = m_gnt_b;
        if (addr == 7) m_frozen = data[0];
        else begin
          m_shadow[addr] = data & reg_mask(addr);
          m_pending = 1;
        end
      end
      if (arm) m_commit_cycle = 1;
    end
    #1;
    check("color1",   color1_o,   m_active[0]);
    check("color2",   color2_o,   m_active[1]);
    check("color3",   color3_o,   m_active[2]);
    check("color4",   color4_o,   m_active[3]);
    check("sprite_x", sprite_x_o, m_active[4]);
    check("sprite_y", sprite_y_o, m_active[5]);
    check("misc",     misc_o,     m_active[6]);
    check("pending",  pending_o,  m_pending);
    check("frozen",   frozen_o,   m_frozen);
    check("commit",   commit_o,   m_commit_exp);
  endtask

  task automatic a_write(input int addr, input int data);
    a_valid_i = 1; a_addr_i = 3'(addr); a_data_i = 8'(data);
    cycle();
    a_valid_i = 0;
  endtask

  initial begin
    set_idle();
    rst_ni = 0;
    model_reset();
    cycle();
    cycle();
    rst_ni = 1;

    // Reset defaults; a frame pulse while idle changes nothing.
    check("rst_color1", color1_o, 'h31);
    check("rst_misc", misc_o, 'h06);
    check("rst_sprite_x", sprite_x_o, 0);
    check("rst_pending", pending_o, 0);
    next_frame = 1; cycle(); next_frame = 0;
    cycle(); cycle();
    check("idle_frame_color1", color1_o, 'h31);

    // Single write then frame commit two cycles after the pulse.
    a_write(4, 37);
    cycle();
    next_frame = 1; cycle(); next_frame = 0;
    check("sx_not_yet", sprite_x_o, 0);
    cycle();
    check("sx_commit", sprite_x_o, 37);
    check("sx_commit_pulse", commit_o, 1);
    check("sx_pending_clr", pending_o, 0);
    cycle();
    check("sx_pulse_end", commit_o, 0);

    // Contention: grants alternate A, B, A, B.
    a_valid_i = 1; a_addr_i = 3'd0; a_data_i = 8'h3F;
    b_valid_i = 1; b_addr_i = 3'd0; b_data_i = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("contend_a_rdy", obs_a_rdy, (i % 2) == 0);
      check("contend_b_rdy", obs_b_rdy, (i % 2) == 1);
    end
    set_idle();
    next_frame = 1; cycle(); next_frame = 0;
    cycle();
    check("contend_color1", color1_o, 'h00);

    // Freeze: frames are ignored until freeze is cleared.
    a_write(7, 1);
    a_write(1, 'h15 | 'hC0);
    a_write(2, 'h2A);
    for (int i = 0; i < 2; i++) begin
      next_frame = 1; cycle(); next_frame = 0;
      cycle(); cycle();
    end
    check("frz_pending", pending_o, 1);
    check("frz_color3", color3_o, 'h0C);
    check("frz_frozen", frozen_o, 1);
    a_write(7, 0);
    cycle();
    next_frame = 1; cycle(); next_frame = 0;
    cycle();
    check("unfrz_color2", color2_o, 'h15);
    check("unfrz_color3", color3_o, 'h2A);
    check("unfrz_commit", commit_o, 1);

    // Write accepted in the frame cycle is included; ready drops next cycle.
    a_write(6, 'h1A);
    next_frame = 1; a_valid_i = 1; a_addr_i = 3'd5; a_data_i = 8'd9;
    cycle();
    check("same_cyc_rdy", obs_a_rdy, 1);
    next_frame = 0; a_data_i = 8'd77;
    cycle();
    check("commit_cyc_rdy", obs_a_rdy, 0);
    a_valid_i = 0;
    check("same_cyc_sy", sprite_y_o, 9);
    check("same_cyc_misc", misc_o, 'h1A);
    next_frame = 1; cycle(); next_frame = 0;
    cycle(); cycle();

    // Reset asserted in the commit cycle discards the update.
    a_write(0, 5);
    next_frame = 1; cycle(); next_frame = 0;
    rst_ni = 0; cycle(); rst_ni = 1;
    check("rst_commit_color1", color1_o, 'h31);
    check("rst_commit_sy", sprite_y_o, 0);
    check("rst_commit_pending", pending_o, 0);
    next_frame = 1; cycle(); next_frame = 0;
    cycle(); cycle();
    check("rst_commit_discard", color1_o, 'h31);

    // Random traffic; a requester that lost holds its request.
    for (int i = 0; i < 600; i++) begin
      if (!(a_valid_i && !m_gnt_a)) begin
        a_valid_i = 1'($urandom_range(0, 1));
        a_addr_i  = 3'($urandom_range(0, 7));
        a_data_i  = 8'($urandom);
        if (a_addr_i == 3'd7) a_data_i[0] = ($urandom_range(0, 3) == 0);
      end
      if (!(b_valid_i && !m_gnt_b)) begin
        b_valid_i = 1'($urandom_range(0, 1));
        b_addr_i  = 3'($urandom_range(0, 7));
        b_data_i  = 8'($urandom);
        if (b_addr_i == 3'd7) b_data_i[0] = ($urandom_range(0, 3) == 0);
      end
      next_frame = ($urandom_range(0, 5) == 0);
      cycle();
    end
    set_idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/config_scheduler.md
# config_scheduler

Frame-synchronous configuration controller for the SVGA sprite display. It accepts register writes from two requesters (A: SPI receiver, B: on-chip animator/test engine) and arbitrates between them round-robin. Accepted writes land in shadow registers; the scheduler commits them to the active registers only at a frame boundary, so the background and sprite logic never see a mid-frame or half-applied update. A freeze control lets the host build multi-register updates that are applied atomically.

## Interface
- COLOR1_DEFAULT, 6'b110001, reset value of color1 (shadow and active)
- COLOR2_DEFAULT, 6'b010101, reset value of color2
- COLOR3_DEFAULT, 6'b001100, reset value of color3
- COLOR4_DEFAULT, 6'b101100, reset value of color4
- SPRITE_X_DEFAULT / SPRITE_Y_DEFAULT, 8'd0, reset sprite position
- MISC_DEFAULT, 5'b00110, reset misc: {reduced_freq, sprite_bg_en, movement_en, bg_sel[1:0]}

Ports:
- clk_i  in  1  pixel clock, 40 MHz. Single clock domain.
- rst_ni  in  1  reset, synchronous, active-low.
- next_frame  in  1  one-cycle frame-boundary pulse from vertical timing.
- a_valid_i / b_valid_i  in  1  write request.
- a_ready_o / b_ready_o  out  1  write accepted when valid && ready.
- a_addr_i / b_addr_i  in  3  register address.
- a_data_i / b_data_i  in  8  write data.
- color1_o..color4_o  out  6 each  active colors.
- sprite_x_o, sprite_y_o  out  8 each  active sprite position.
- misc_o  out  5  active misc.
- pending_o  out  1  uncommitted shadow data exists.
- frozen_o  out  1  current freeze bit.
- commit_o  out  1  one-cycle pulse in the cycle the active registers first show new values.

## Operation
- Address map: 0-3 color1-4 (data[5:0]), 4 sprite_x, 5 sprite_y, 6 misc (data[4:0]), 7 control (data[0] = freeze; other bits ignored). Unused data bits are ignored.
- Arbitration: at most one write is accepted per cycle.
  - One requester valid: it is granted.
  - Both valid: the requester not granted in the last contested cycle wins. After reset, A wins the first contest.
  - The loser's ready is 0 and it holds its request.
- Write to addr 0-6: updates the shadow register and sets its dirty bit.
- Write to addr 7: updates freeze immediately. It does not set a dirty bit and does not change state.
- FSM states:
  - IDLE → ARMED on any accepted write to addr 0-6.
  - ARMED: writes still accepted. ARMED → COMMIT on next_frame && !freeze. next_frame with freeze=1 is ignored; state stays ARMED.
  - COMMIT lasts exactly one cycle. Every dirty shadow register is copied to active, all dirty bits clear, and COMMIT → IDLE.
- Ready rules: a_ready_o = b_ready_o = 0 in COMMIT and in reset. Otherwise ready follows the arbiter.
- pending_o = (state != IDLE). frozen_o = freeze.
- Reset values:
  - All shadow and active registers take their parameter defaults.
  - freeze=0, dirty=0, state=IDLE.
  - commit_o=0, pending_o=0.
  - Arbiter pointer favours A.

## Timing
- Write accepted at edge t: the shadow register holds the value from t+1.
- next_frame high in cycle f while ARMED and not frozen:
  - COMMIT occupies cycle f+1.
  - Active outputs and commit_o=1 appear in cycle f+2.
- A write accepted in cycle f (same cycle as next_frame) is included in that commit.
- No write can be accepted in cycle f+1, because ready is 0.
- Back-to-back writes to the same address: the last accepted value wins.
- Freeze cleared while ARMED: commit occurs at the next next_frame after clearing, not retroactively.
- next_frame while IDLE: no action. next_frame while COMMIT: ignored.
- rst_ni low in any state, including COMMIT: everything returns to reset values on that edge, and a partial commit is discarded.
- All outputs are registered. There are no combinational paths from inputs to active outputs.

## Structure
- Shared package config_sched_pkg contains:
  - address enum: ADDR_COLOR1..ADDR_CTRL.
  - state enum: IDLE, ARMED, COMMIT.
  - default-value localparams shared with the top level.
- Sub-module rr_arbiter2: two-requester round-robin arbiter with a 1-bit last-winner pointer and grant outputs. It is reused later for sprite-data access sharing.
- The shadow/active banks and dirty mask are plain registers in config_scheduler. No memory macro.

## Test plan
- Reset with defaults: outputs show color1=6'b110001, misc=5'b00110, sprite_x=0, pending_o=0; pulse next_frame and nothing changes.
- A writes addr 4 ← 8'd37, then next_frame pulses: sprite_x_o=37 two cycles after the pulse, commit_o one-cycle high, pending_o back to 0.
- Contention, A and B valid for 4 cycles:
  - A: addr 0 ← 6'h3F. B: addr 0 ← 6'h00, both held.
  - Grants alternate A, B, A, B.
  - After the commit, color1_o equals the data of the final accepted write.
- Freeze sequence:
  - A writes addr 7 ← 1, addr 1 ← 6'h15, addr 2 ← 6'h2A.
  - Two next_frame pulses: no change, pending_o=1.
  - A writes addr 7 ← 0; at the next next_frame, color2 and color3 update in the same cycle.
- Same-cycle write and frame:
  - A write to addr 5 ← 8'd9 is accepted in the next_frame cycle and is committed by that frame.
  - Ready is 0 in the following cycle.
- Reset mid-operation: rst_ni low during the COMMIT cycle → all active registers take their defaults, shadow registers are discarded, state is IDLE.
